// File: rtl/vertex_feeder_if.sv
// Bus between the vertex feeder and its environment: batch control, vertex
// RAM read port, transform-stage request/response and result RAM write port.
interface vertex_feeder_if #(
    parameter int ADDR_W = 8
);
    logic                       start;
    logic [ADDR_W-1:0]          num_verts;
    logic [ADDR_W-1:0]          vert_addr;
    logic [127:0]               vert_data;
    logic [3:0][31:0]           xf_pos;
    logic                       xf_valid;
    logic [3:0][31:0]           xf_result;
    logic                       xf_result_valid;
    logic                       res_we;
    logic [ADDR_W-1:0]          res_addr;
    logic [127:0]               res_data;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [ADDR_W-1:0]          count;

    // Feeder side
    modport master (
        input  start, num_verts, vert_data, xf_result, xf_result_valid,
        output vert_addr, xf_pos, xf_valid, res_we, res_addr, res_data,
               busy, done, err, count
    );

    // Environment side (RAMs, transform stage, batch controller)
    modport slave (
        output start, num_verts, vert_data, xf_result, xf_result_valid,
        input  vert_addr, xf_pos, xf_valid, res_we, res_addr, res_data,
               busy, done, err, count
    );
endinterface

// File: rtl/vertex_feeder.sv
// Vertex feeder: walks a batch of vertices through a single-entry transform
// stage (one request outstanding at a time) and writes each transformed
// vertex to the result RAM at the same index. A missing transform response
// aborts the batch with a sticky error. Every output is a register.
module vertex_feeder #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk_in,
    input  logic            rst_in,
    vertex_feeder_if.master bus
);
    localparam int FCNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(READ_LAT - 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_WAIT, S_WRITE} state_t;

    state_t              r_state, w_next;

    logic [ADDR_W-1:0]   r_i, w_i_n;
    logic [ADDR_W-1:0]   r_num, w_num_n;
    logic [FCNT_W-1:0]   r_fcnt, w_fcnt_n;
    logic [TMO_W-1:0]    r_tmo, w_tmo_n;

    logic [ADDR_W-1:0]   r_vaddr, w_vaddr_n;
    logic [3:0][31:0]    r_xf_pos, w_xf_pos_n;
    logic                r_xf_valid, w_xf_valid_n;
    logic                r_res_we, w_res_we_n;
    logic [ADDR_W-1:0]   r_res_addr, w_res_addr_n;
    logic [127:0]        r_res_data, w_res_data_n;
    logic                r_busy, w_busy_n;
    logic                r_done, w_done_n;
    logic                r_err, w_err_n;
    logic [ADDR_W-1:0]   r_count, w_count_n;

    logic                w_last;
    logic                w_accept;

    // Last vertex of the batch; r_num is never zero while a batch runs
    assign w_last   = (r_i == r_num - 1'b1);
    // A response counts in SEND (same cycle as the request) or in WAIT only
    assign w_accept = ((r_state == S_SEND) || (r_state == S_WAIT)) && bus.xf_result_valid;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start && (bus.num_verts != '0)) w_next = S_FETCH;
            S_FETCH: if (r_fcnt == FETCH_LAST) w_next = S_SEND;
            S_SEND:  w_next = bus.xf_result_valid ? S_WRITE : S_WAIT;
            S_WAIT: begin
                if (bus.xf_result_valid)    w_next = S_WRITE;
                else if (r_tmo == TMO_LAST) w_next = S_IDLE;
            end
            S_WRITE: w_next = w_last ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the output and datapath registers
    always_comb begin
        w_i_n        = r_i;
        w_num_n      = r_num;
        w_fcnt_n     = r_fcnt;
        w_tmo_n      = r_tmo;
        w_vaddr_n    = r_vaddr;
        w_xf_pos_n   = r_xf_pos;
        w_xf_valid_n = 1'b0;
        w_res_we_n   = 1'b0;
        w_res_addr_n = r_res_addr;
        w_res_data_n = r_res_data;
        w_busy_n     = (w_next != S_IDLE);
        w_done_n     = 1'b0;
        w_err_n      = r_err;
        w_count_n    = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_err_n = 1'b0;
                    if (bus.num_verts != '0) begin
                        w_num_n   = bus.num_verts;
                        w_i_n     = '0;
                        w_count_n = '0;
                        w_vaddr_n = '0;
                        w_fcnt_n  = '0;
                    end else begin
                        w_done_n = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // vert_addr has been stable for READ_LAT cycles on the last one
                if (r_fcnt == FETCH_LAST) begin
                    w_xf_pos_n   = bus.vert_data;
                    w_xf_valid_n = 1'b1;
                end else begin
                    w_fcnt_n = r_fcnt + 1'b1;
                end
            end
            S_SEND: w_tmo_n = '0;
            S_WAIT: begin
                if (!bus.xf_result_valid) begin
                    if (r_tmo == TMO_LAST) begin
                        w_err_n  = 1'b1;
                        w_done_n = 1'b1;
                    end else begin
                        w_tmo_n = r_tmo + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (!w_last) begin
                    w_i_n     = r_i + 1'b1;
                    w_vaddr_n = r_i + 1'b1;
                    w_fcnt_n  = '0;
                end
            end
            default: ;
        endcase
        if (w_accept) begin
            w_res_data_n = bus.xf_result;
            w_res_we_n   = 1'b1;
            w_res_addr_n = r_i;
            w_count_n    = r_i + 1'b1;
            w_done_n     = w_last;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_i        <= '0;
            r_num      <= '0;
            r_fcnt     <= '0;
            r_tmo      <= '0;
            r_vaddr    <= '0;
            r_xf_pos   <= '0;
            r_xf_valid <= 1'b0;
            r_res_we   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_i        <= w_i_n;
            r_num      <= w_num_n;
            r_fcnt     <= w_fcnt_n;
            r_tmo      <= w_tmo_n;
            r_vaddr    <= w_vaddr_n;
            r_xf_pos   <= w_xf_pos_n;
            r_xf_valid <= w_xf_valid_n;
            r_res_we   <= w_res_we_n;
            r_res_addr <= w_res_addr_n;
            r_res_data <= w_res_data_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_count    <= w_count_n;
        end
    end

    assign bus.vert_addr = r_vaddr;
    assign bus.xf_pos    = r_xf_pos;
    assign bus.xf_valid  = r_xf_valid;
    assign bus.res_we    = r_res_we;
    assign bus.res_addr  = r_res_addr;
    assign bus.res_data  = r_res_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_vertex_feeder.sv
// Directed testbench for vertex_feeder: vertex RAM model (vertex k at
// address k), a transform model adding 10.0 to word 1 after a chosen
// latency, and a bus monitor logging writes, done pulses and requests.
module tb_vertex_feeder;
    localparam int TIMEOUT = 255;

    logic clk    = 1'b0;
    logic rst_in = 1'b1;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    vertex_feeder_if #(.ADDR_W(8)) bus();

    vertex_feeder #(.ADDR_W(8), .READ_LAT(2), .TIMEOUT(TIMEOUT)) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Vertex k: pos0=A000_0000+k, pos1=float(k), pos2=B000_0000+k, pos3=1.0
    function automatic logic [127:0] vtx(input logic [7:0] k);
        logic [31:0] p1;
        case (k)
            8'd0: p1 = 32'h0000_0000;
            8'd1: p1 = 32'h3F80_0000;
            8'd2: p1 = 32'h4000_0000;
            8'd3: p1 = 32'h4040_0000;
            default: p1 = 32'h4080_0000;
        endcase
        return {32'h3F80_0000, 32'hB000_0000 + {24'h0, k}, p1, 32'hA000_0000 + {24'h0, k}};
    endfunction

    // Expected result for vertex k: pos1 = float(k) + 10.0
    function automatic logic [127:0] exp_res(input logic [7:0] k);
        logic [31:0] p1;
        case (k)
            8'd0: p1 = 32'h4120_0000;
            8'd1: p1 = 32'h4130_0000;
            8'd2: p1 = 32'h4140_0000;
            default: p1 = 32'h4150_0000;
        endcase
        return {32'h3F80_0000, 32'hB000_0000 + {24'h0, k}, p1, 32'hA000_0000 + {24'h0, k}};
    endfunction

    function automatic logic [31:0] add10(input logic [31:0] x);
        case (x)
            32'h0000_0000: return 32'h4120_0000;
            32'h3F80_0000: return 32'h4130_0000;
            32'h4000_0000: return 32'h4140_0000;
            32'h4040_0000: return 32'h4150_0000;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [127:0] xform(input logic [127:0] x);
        logic [127:0] r;
        r = x;
        r[63:32] = add10(x[63:32]);
        return r;
    endfunction

    // Vertex RAM: one register stage after the address, data valid 2 cycles after it changes
    always @(posedge clk) bus.vert_data <= vtx(bus.vert_addr);

    // Transform model plus a forced path for stray/late responses
    bit           model_en = 1'b0;
    int           m_lat = 0;
    int           m_cnt = 0;
    logic         m_valid = 1'b0;
    logic [127:0] m_data = '0;
    logic [127:0] m_pend = '0;
    logic         f_valid = 1'b0;
    logic [127:0] f_data = '0;

    assign bus.xf_result_valid = m_valid | f_valid;
    assign bus.xf_result       = f_valid ? f_data : m_data;

    always begin
        @(posedge clk); #1;
        m_valid = 1'b0;
        if (!model_en) begin
            m_cnt = 0;
        end else if (bus.xf_valid) begin
            m_pend = xform(bus.xf_pos);
            if (m_lat == 0) begin m_valid = 1'b1; m_data = m_pend; end
            else m_cnt = m_lat;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_valid = 1'b1; m_data = m_pend; end
        end
    end

    // Monitor sampled on the falling edge
    logic [7:0]   we_addr[$];
    logic [127:0] we_data[$];
    int           done_cyc[$];
    int           xfv_cyc[$];
    int           n_busy = 0;

    always @(negedge clk) begin
        if (bus.res_we) begin we_addr.push_back(bus.res_addr); we_data.push_back(bus.res_data); end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.xf_valid) xfv_cyc.push_back(cyc);
        if (bus.busy) n_busy++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        we_addr.delete(); we_data.delete(); done_cyc.delete(); xfv_cyc.delete(); n_busy = 0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        bus.start = 1'b0; bus.num_verts = '0;
        rst_in = 1'b1;
        repeat (2) tick();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", bus.err); end
        n_tests++; if (bus.xf_valid !== 1'b0 || bus.res_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got xf_valid=%0h res_we=%0h want 0", bus.xf_valid, bus.res_we); end
        n_tests++; if (bus.count !== 8'd0 || bus.vert_addr !== 8'd0 || bus.res_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got count=%0h vaddr=%0h raddr=%0h want 0", bus.count, bus.vert_addr, bus.res_addr); end
        n_tests++; if (bus.xf_pos !== '0 || bus.res_data !== '0) begin n_fail++; $display("FAIL reset_data: got xf_pos=%h res_data=%h want 0", bus.xf_pos, bus.res_data); end
        // Start on the very first edge after reset release; L=0 exercises acceptance in SEND
        model_en = 1'b1; m_lat = 0;
        rst_in = 1'b0; bus.start = 1'b1; bus.num_verts = 8'd1;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL first_start_busy: got %0h want 1", bus.busy); end
        wait_done(50, seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL first_start_done: got %0h want 1", seen); end
        n_tests++; if (bus.res_data !== exp_res(0)) begin n_fail++; $display("FAIL send_accept_data: got %h want %h", bus.res_data, exp_res(0)); end
        tick();
    endtask

    task automatic test_batch3();
        bit seen;
        clear_log();
        model_en = 1'b1; m_lat = 4;
        bus.start = 1'b1; bus.num_verts = 8'd3;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.busy !== 1'b1 || bus.vert_addr !== 8'd0) begin n_fail++; $display("FAIL b3_start: got busy=%0h vaddr=%0h want 1/0", bus.busy, bus.vert_addr); end
        n_tests++; if (bus.xf_valid !== 1'b0) begin n_fail++; $display("FAIL b3_xfv_c1: got %0h want 0", bus.xf_valid); end
        tick();
        n_tests++; if (bus.xf_valid !== 1'b0) begin n_fail++; $display("FAIL b3_xfv_c2: got %0h want 0", bus.xf_valid); end
        tick();
        n_tests++; if (bus.xf_valid !== 1'b1) begin n_fail++; $display("FAIL b3_xfv_c3: got %0h want 1", bus.xf_valid); end
        n_tests++; if (bus.xf_pos !== vtx(0)) begin n_fail++; $display("FAIL b3_xf_pos: got %h want %h", bus.xf_pos, vtx(0)); end
        wait_done(200, seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL b3_done_seen: got %0h want 1", seen); end
        repeat (3) tick();
        n_tests++; if (we_addr.size() !== 3) begin n_fail++; $display("FAIL b3_nwrites: got %0d want 3", we_addr.size()); end
        for (int k = 0; k < 3 && k < we_addr.size(); k++) begin
            n_tests++; if (we_addr[k] !== 8'(k)) begin n_fail++; $display("FAIL b3_addr%0d: got %0h want %0h", k, we_addr[k], k); end
            n_tests++; if (we_data[k] !== exp_res(8'(k))) begin n_fail++; $display("FAIL b3_data%0d: got %h want %h", k, we_data[k], exp_res(8'(k))); end
        end
        n_tests++; if (done_cyc.size() !== 1) begin n_fail++; $display("FAIL b3_ndone: got %0d want 1", done_cyc.size()); end
        n_tests++; if (bus.count !== 8'd3 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b3_final: got count=%0h err=%0h busy=%0h want 3/0/0", bus.count, bus.err, bus.busy); end
    endtask

    task automatic test_zero();
        clear_log();
        bus.start = 1'b1; bus.num_verts = 8'd0;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0h want 1", bus.done); end
        tick();
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %0h want 0", bus.done); end
        repeat (4) tick();
        n_tests++; if (xfv_cyc.size() !== 0 || we_addr.size() !== 0) begin n_fail++; $display("FAIL zero_activity: got xfv=%0d writes=%0d want 0/0", xfv_cyc.size(), we_addr.size()); end
        n_tests++; if (n_busy !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles want 0", n_busy); end
    endtask

    task automatic test_timeout();
        bit seen;
        clear_log();
        model_en = 1'b0;
        bus.start = 1'b1; bus.num_verts = 8'd1;
        tick();
        bus.start = 1'b0;
        wait_done(400, seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_done_seen: got %0h want 1", seen); end
        tick();
        n_tests++; if (done_cyc.size() !== 1 || xfv_cyc.size() !== 1 || done_cyc[0] - xfv_cyc[0] !== TIMEOUT + 1) begin
            n_fail++; $display("FAIL tmo_latency: got done-xfv=%0d want %0d", (done_cyc.size() > 0 && xfv_cyc.size() > 0) ? done_cyc[0] - xfv_cyc[0] : -1, TIMEOUT + 1);
        end
        repeat (3) tick();
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %0h want 1", bus.err); end
        n_tests++; if (we_addr.size() !== 0) begin n_fail++; $display("FAIL tmo_no_write: got %0d writes want 0", we_addr.size()); end
        model_en = 1'b1; m_lat = 2;
        bus.start = 1'b1; bus.num_verts = 8'd1;
        tick();
        bus.start = 1'b0;
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %0h want 0", bus.err); end
        wait_done(100, seen);
        tick();
        n_tests++; if (we_addr.size() !== 1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL tmo_recover: got writes=%0d err=%0h want 1/0", we_addr.size(), bus.err); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        clear_log();
        model_en = 1'b1; m_lat = 1;
        bus.start = 1'b1; bus.num_verts = 8'd4;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.start = 1'b1; bus.num_verts = 8'd2;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(200, seen);
        repeat (4) tick();
        n_tests++; if (we_addr.size() !== 4) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 4", we_addr.size()); end
        n_tests++; if (we_addr.size() == 4 && (we_addr[3] !== 8'd3 || we_data[3] !== exp_res(3))) begin n_fail++; $display("FAIL b2b_last: got addr=%0h data=%h want 3/%h", we_addr[3], we_data[3], exp_res(3)); end
        n_tests++; if (bus.count !== 8'd4 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_final: got count=%0h busy=%0h want 4/0", bus.count, bus.busy); end
        n_tests++; if (xfv_cyc.size() < 2 || xfv_cyc[1] - xfv_cyc[0] !== 5) begin n_fail++; $display("FAIL b2b_vertex_period: got %0d want 5", (xfv_cyc.size() >= 2) ? xfv_cyc[1] - xfv_cyc[0] : -1); end
    endtask

    task automatic test_stray();
        bit seen;
        clear_log();
        model_en = 1'b1; m_lat = 3;
        f_data = {4{32'h5555_5555}};
        f_valid = 1'b1;
        tick();
        f_valid = 1'b0;
        repeat (2) tick();
        n_tests++; if (we_addr.size() !== 0 || bus.busy !== 1'b0 || done_cyc.size() !== 0) begin n_fail++; $display("FAIL stray_idle: got writes=%0d busy=%0h dones=%0d want 0/0/0", we_addr.size(), bus.busy, done_cyc.size()); end
        bus.start = 1'b1; bus.num_verts = 8'd1;
        tick();
        bus.start = 1'b0;
        f_valid = 1'b1;
        tick();
        f_valid = 1'b0;
        tick();
        n_tests++; if (bus.xf_valid !== 1'b1 || we_addr.size() !== 0) begin n_fail++; $display("FAIL stray_fetch: got xf_valid=%0h writes=%0d want 1/0", bus.xf_valid, we_addr.size()); end
        wait_done(100, seen);
        tick();
        n_tests++; if (we_addr.size() !== 1 || we_data[0] !== exp_res(0) || we_addr[0] !== 8'd0) begin n_fail++; $display("FAIL stray_batch: got writes=%0d data=%h want 1/%h", we_addr.size(), (we_data.size() > 0) ? we_data[0] : '0, exp_res(0)); end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_log();
        model_en = 1'b1; m_lat = 2;
        bus.start = 1'b1; bus.num_verts = 8'd3;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin tick(); if (we_addr.size() == 1) found = 1'b1; end
        model_en = 1'b0;
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_first_write: got %0h want 1", found); end
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin tick(); if (bus.xf_valid) found = 1'b1; end
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_send1: got %0h want 1", found); end
        tick();
        rst_in = 1'b1;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.count !== 8'd0 || bus.vert_addr !== 8'd0 || bus.xf_pos !== '0 || bus.res_data !== '0) begin
            n_fail++; $display("FAIL rmid_async: got busy=%0h count=%0h vaddr=%0h xf_pos=%h res_data=%h want all 0", bus.busy, bus.count, bus.vert_addr, bus.xf_pos, bus.res_data);
        end
        tick();
        rst_in = 1'b0;
        tick();
        f_data = xform(vtx(1)); f_valid = 1'b1;
        tick();
        f_valid = 1'b0;
        repeat (4) tick();
        n_tests++; if (we_addr.size() !== 1) begin n_fail++; $display("FAIL rmid_no_write: got %0d writes want 1", we_addr.size()); end
        n_tests++; if (bus.busy !== 1'b0 || bus.res_we !== 1'b0 || bus.count !== 8'd0) begin n_fail++; $display("FAIL rmid_idle: got busy=%0h res_we=%0h count=%0h want 0/0/0", bus.busy, bus.res_we, bus.count); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.num_verts = '0;
        test_reset();
        test_batch3();
        test_zero();
        test_timeout();
        test_back_to_back();
        test_stray();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
